pipo_shift_register: RTL and testbench

PIPO_SHIFT_REGISTER -- requirements
Module: pipo_shift_register

---
 rtl/pipo_pkg.sv | 13 +
 rtl/pipo_shift_register_if.sv | 39 +++
 rtl/pipo_shift_counter.sv | 37 +++
 rtl/pipo_shift_register.sv | 79 +++++++
 tb/tb_pipo_shift_register.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipo_pkg.sv
// Shared constants for the PIPO shift register: shift direction encoding and default width.
package pipo_pkg;

  localparam logic DIR_LEFT      = 1'b0;
  localparam logic DIR_RIGHT     = 1'b1;
  localparam int   DEFAULT_WIDTH = 8;

  // Width of a counter that must hold every value 0..max inclusive.
  function automatic int count_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pipo_shift_register_if.sv
// Parallel/serial bus of the PIPO shift register; the rotate strobe exists only
// when PIPO_SHIFT_REGISTER_ROTATE_EN is defined.
interface pipo_shift_register_if
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CW = count_w(WIDTH);

  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic             shift_dir;
  logic             serial_in;
`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
  logic             rotate;
`endif
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             valid;
  logic [CW-1:0]    shift_count;

  modport master (
    output load, data_in, shift_en, shift_dir, serial_in,
`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
    output rotate,
`endif
    input  data_out, serial_out, valid, shift_count
  );

  modport slave (
    input  load, data_in, shift_en, shift_dir, serial_in,
`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
    input  rotate,
`endif
    output data_out, serial_out, valid, shift_count
  );

endinterface

// File: rtl/pipo_shift_counter.sv
// Saturating up-counter with synchronous clear (priority over increment) and
// asynchronous active-low reset.
module pipo_shift_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipo_shift_register.sv
// Parallel-in/parallel-out shift register with serial fill and a saturating shift
// counter; defining PIPO_SHIFT_REGISTER_ROTATE_EN adds a rotate mode.
module pipo_shift_register
  import pipo_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  pipo_shift_register_if.slave       bus
);

  localparam int CW = count_w(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             out_bit;
  logic             fill_bit;
  logic             shift_take;

  // A shift coinciding with a load is dropped entirely, including its count.
  assign shift_take = bus.shift_en && !bus.load;

  always_comb begin
    out_bit = (bus.shift_dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
    fill_bit = bus.rotate ? out_bit : bus.serial_in;
`else
    fill_bit = bus.serial_in;
`endif
  end

  always_comb begin
    data_d  = data_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    if (bus.load) begin
      data_d  = bus.data_in;
      valid_d = 1'b1;
    end else if (bus.shift_en) begin
      sout_d = out_bit;
      if (bus.shift_dir == DIR_LEFT) begin
        data_d = {data_q[WIDTH-2:0], fill_bit};
      end else begin
        data_d = {fill_bit, data_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= RESET_VALUE;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
    end
  end

  pipo_shift_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (bus.load),
    .inc_i   (shift_take),
    .count_o (bus.shift_count)
  );

  assign bus.data_out   = data_q;
  assign bus.serial_out = sout_q;
  assign bus.valid      = valid_q;

endmodule

// File: tb/tb_pipo_shift_register.sv
// Directed plus randomized bench for pipo_shift_register against an arithmetic
// reference model; rotate steps are included when PIPO_SHIFT_REGISTER_ROTATE_EN is defined.
module tb_pipo_shift_register;
  import pipo_pkg::*;

  localparam int W    = 8;
  localparam int HALF = 2 ** (W - 1);
  localparam int FULL = 2 ** W;

  logic clk = 1'b0;
  logic reset;

  pipo_shift_register_if #(.WIDTH(W)) bus ();

  pipo_shift_register #(
    .WIDTH       (W),
    .RESET_VALUE ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   m_data, m_sout, m_valid, m_cnt;
  logic rot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},    32'(bus.data_out),    32'(m_data));
    chk({tag, ".serial_out"},  32'(bus.serial_out),  32'(m_sout));
    chk({tag, ".valid"},       32'(bus.valid),       32'(m_valid));
    chk({tag, ".shift_count"}, 32'(bus.shift_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_data  = 0;
    m_sout  = 0;
    m_valid = 0;
    m_cnt   = 0;
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] din, input logic sen,
                       input logic dir, input logic sin, input logic r);
    bus.load      = ld;
    bus.data_in   = din;
    bus.shift_en  = sen;
    bus.shift_dir = dir;
    bus.serial_in = sin;
`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
    bus.rotate    = r;
    rot           = r;
`else
    rot           = 1'b0 & r;
`endif
  endtask

  // One clock edge: predict from the present inputs, then sample 1 time unit later.
  task automatic tick();
    int nd, ns, nv, nc, outb, fillb;
    nd = m_data; ns = m_sout; nv = m_valid; nc = m_cnt;
    if (bus.load) begin
      nd = int'(bus.data_in);
      nv = 1;
      nc = 0;
    end else if (bus.shift_en) begin
      if (bus.shift_dir == DIR_RIGHT) begin
        outb  = m_data % 2;
        fillb = rot ? outb : int'(bus.serial_in);
        nd    = m_data / 2 + fillb * HALF;
      end else begin
        outb  = m_data / HALF;
        fillb = rot ? outb : int'(bus.serial_in);
        nd    = (m_data * 2) % FULL + fillb;
      end
      ns = outb;
      nc = (m_cnt < W) ? m_cnt + 1 : W;
    end
    @(posedge clk);
    #1;
    m_data = nd; m_sout = ns; m_valid = nv; m_cnt = nc;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    #2 reset = 1'b1;
    tick();
    check_all("after_release");

    // Shifting before any load works on the reset value and keeps valid low.
    drive(1'b0, '0, 1'b1, DIR_LEFT, 1'b1, 1'b0);
    tick();
    tick();
    check_all("shift_preload");
    chk("shift_preload.const", 32'(bus.data_out), 32'h03);

    drive(1'b1, 8'b10101010, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    tick();
    check_all("load_AA");
    chk("load_AA.const", 32'(bus.data_out), 32'hAA);
    drive(1'b0, 8'h00, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    tick();
    tick();
    check_all("hold_AA");

    drive(1'b1, 8'hA5, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, DIR_LEFT, 1'b1, 1'b0);
    repeat (3) tick();
    check_all("left3");
    chk("left3.const_data", 32'(bus.data_out), 32'h2F);
    chk("left3.const_sout", 32'(bus.serial_out), 32'h1);
    chk("left3.const_cnt", 32'(bus.shift_count), 32'd3);

    drive(1'b1, 8'h3C, 1'b1, DIR_RIGHT, 1'b0, 1'b0);
    tick();
    check_all("load_and_shift");
    chk("load_and_shift.const", 32'(bus.data_out), 32'h3C);

    drive(1'b1, 8'h81, 1'b0, DIR_RIGHT, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, DIR_RIGHT, 1'b0, 1'b0);
    repeat (10) tick();
    check_all("right10");
    chk("right10.const_data", 32'(bus.data_out), 32'h00);
    chk("right10.const_cnt", 32'(bus.shift_count), 32'd8);

`ifdef PIPO_SHIFT_REGISTER_ROTATE_EN
    drive(1'b1, 8'h81, 1'b0, DIR_RIGHT, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, DIR_RIGHT, 1'b0, 1'b1);
    repeat (8) tick();
    check_all("rotate8");
    chk("rotate8.const", 32'(bus.data_out), 32'h81);
    drive(1'b0, 8'h00, 1'b1, DIR_LEFT, 1'b0, 1'b1);
    repeat (3) tick();
    check_all("rotate_left3");
`endif

    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      check_all("random");
    end

    // Asynchronous reset between edges in the middle of a shift run.
    drive(1'b1, 8'hFF, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, DIR_LEFT, 1'b0, 1'b0);
    tick();
    tick();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    drive(1'b1, 8'h77, 1'b1, DIR_LEFT, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_ignores_inputs");
    #3 reset = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, DIR_LEFT, 1'b0, 1'b0);
    tick();
    check_all("resume_load");
    drive(1'b0, 8'h00, 1'b1, DIR_RIGHT, 1'b1, 1'b0);
    tick();
    check_all("resume_shift");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
